sd_sched: RTL and testbench
===========================

Name: sd_sched

Overview:
Round-robin scheduler that shares one serial sequence-detector instance among NREQ requesters.
- Grants one requester at a time and latches its FRAME_W-bit frame.
- Clears the detector, serializes the frame MSB-first onto the detector input, and counts detector hit cycles.
- Returns a per-frame result tagged with the requester index.
- Sits between the requester ports and the detector (pattern input, Dout output, async reset).

Parameters:
- NREQ, 2, number of requesters (2..8).
- FRAME_W, 15, bits per frame.
- CNT_W, 4, hit-counter width; must be at least clog2(FRAME_W+1).
- ID_W, 1, requester index width; must be at least clog2(NREQ).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request; hold high until granted
- frame_data  in  NREQ*FRAME_W  requester i frame at bits [i*FRAME_W +: FRAME_W]
- gnt  out  NREQ  one-hot, one-cycle accept pulse; frame captured on that edge
- pattern_out  out  1  serial bit to detector pattern input
- det_rst  out  1  registered clear pulse to detector async reset
- det_hit  in  1  detector Dout
- busy  out  1  high in every state except IDLE
- res_valid  out  1  one-cycle result strobe
- res_id  out  ID_W  index of the requester whose frame produced the result
- res_hits  out  CNT_W  number of window cycles with det_hit=1

Behaviour:
- All outputs are registered. Reset values: gnt=0, pattern_out=0, det_rst=0, busy=0, res_valid=0, res_id=0, res_hits=0.
- On reset, FSM goes to IDLE and the round-robin pointer last = NREQ-1, so req[0] has first priority.
- FSM states: IDLE, ARB, CLR, SHIFT, DRAIN, REPORT.
- IDLE: if any req is set, go to ARB; otherwise stay.
- ARB (1 cycle):
  - Search starts at index last+1 and wraps modulo NREQ; the first set req wins.
  - gnt[win] pulses; the frame is latched into the shift register; res_id and last are set to win.
  - Go to CLR.
  - If req drops to all-zero at ARB (illegal), return to IDLE with no gnt.
- CLR (1 cycle): det_rst=1; hit counter cleared; bit index cleared; go to SHIFT.
- SHIFT (FRAME_W cycles): pattern_out = frame bit FRAME_W-1-idx for idx = 0..FRAME_W-1; after the last bit, go to DRAIN.
- DRAIN (2 cycles): pattern_out=0; then go to REPORT.
- Detector latency is 2 cycles: det_hit sampled in cycle k+2 reflects bit k.
- Hit window = SHIFT cycles idx=2..FRAME_W-1 plus both DRAIN cycles, which is exactly FRAME_W samples.
- Each window sample with det_hit=1 increments the counter; the counter saturates at 2^CNT_W-1.
- REPORT (1 cycle): res_valid=1, res_hits=counter; res_id held; go to IDLE.
- res_id and res_hits hold their values until the next REPORT.
- Timing from gnt in cycle T: det_rst in T+1, SHIFT T+2..T+FRAME_W+1, res_valid in T+FRAME_W+4 (T+19 at defaults).
- Minimum spacing between grants is FRAME_W+5 cycles. New requests are ignored while busy; a request raised during REPORT is served via IDLE→ARB.
- Simultaneous requests are served strictly round-robin, one per frame.
- Reset mid-operation aborts the frame immediately: no res_valid; det_rst returns to 0; the pointer reloads to NREQ-1.
- det_hit is ignored outside the window.

Optional Feature:
- Macro: SD_SCHED_FIRST_HIT_EN.
- When defined:
  - Adds output res_first (CNT_W bits): the 0-based bit index k of the first window sample with det_hit=1.
  - res_first = all-ones if the frame has no hit.
  - Updated in REPORT alongside res_hits; reset value all-ones.
- When undefined: no port and no logic.

Test Plan:
- req=01, frame0=15'h7000 → gnt=01 pulse; res_valid exactly 19 cycles after gnt; res_id=0, res_hits=12 (res_first=3 with macro).
- req=10, frame1=15'h7600 → res_id=1, res_hits=10 (res_first=3).
- req=11 held high, frames 0x7000/0x0000 → grants alternate 01,10,01; results 12, 0, 12; each gnt spaced 20 cycles apart.
- frame=15'h0000 → res_hits=0 (res_first=all-ones); det_hit pulsed outside the window is not counted.
- Assert rst during SHIFT → all outputs 0 within the same cycle, no res_valid; next req=11 is granted to req[0].
- req raised during REPORT cycle → gnt issued 2 cycles later (IDLE, then ARB).

Source files
------------

// File: rtl/sd_sched_if.sv
// Requester-side bundle for sd_sched: request/frame in, grant and result out.
// Carries res_first only when SD_SCHED_FIRST_HIT_EN is defined.
interface sd_sched_if #(
    parameter int NREQ    = 2,
    parameter int FRAME_W = 15,
    parameter int CNT_W   = 4,
    parameter int ID_W    = 1
);
    logic [NREQ-1:0]         req;
    logic [NREQ*FRAME_W-1:0] frame_data;
    logic [NREQ-1:0]         gnt;
    logic                    res_valid;
    logic [ID_W-1:0]         res_id;
    logic [CNT_W-1:0]        res_hits;
`ifdef SD_SCHED_FIRST_HIT_EN
    logic [CNT_W-1:0]        res_first;

    modport master (
        output req, frame_data,
        input  gnt, res_valid, res_id, res_hits, res_first
    );
    modport slave (
        input  req, frame_data,
        output gnt, res_valid, res_id, res_hits, res_first
    );
`else
    modport master (
        output req, frame_data,
        input  gnt, res_valid, res_id, res_hits
    );
    modport slave (
        input  req, frame_data,
        output gnt, res_valid, res_id, res_hits
    );
`endif
endinterface

// File: rtl/sd_sched.sv
// Round-robin scheduler sharing one serial sequence detector among NREQ requesters.
// Define SD_SCHED_FIRST_HIT_EN to also report the index of the first hit (res_first).
module sd_sched #(
    parameter int NREQ    = 2,
    parameter int FRAME_W = 15,
    parameter int CNT_W   = 4,
    parameter int ID_W    = 1
) (
    input  logic      clk,
    input  logic      rst,
    sd_sched_if.slave bus,
    output logic      pattern_out,
    output logic      det_rst,
    input  logic      det_hit,
    output logic      busy
);
    localparam int IW = (FRAME_W > 2) ? $clog2(FRAME_W) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARB    = 3'd1;
    localparam logic [2:0] S_CLR    = 3'd2;
    localparam logic [2:0] S_SHIFT  = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_REPORT = 3'd5;

    logic [2:0]         state, state_nxt;
    logic [ID_W-1:0]    last, win, res_id;
    logic               found;
    logic [NREQ-1:0]    gnt;
    logic [FRAME_W-1:0] shreg;
    logic [IW-1:0]      idx;
    logic [CNT_W-1:0]   cnt, cnt_nxt, res_hits;
    logic               res_valid;
    logic               in_win, hit;

    always_comb begin
        int c;
        c     = 0;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            c = (int'(last) + i) % NREQ;
            if (!found && |(bus.req & (NREQ'(1) << c))) begin
                found = 1'b1;
                win   = ID_W'(c);
            end
        end
    end

    // Outputs lag the state by one cycle, so the detector response to bit k
    // arrives while the FSM is three steps further on; the window tracks that.
    assign in_win = (state == S_SHIFT && idx >= IW'(3))
                  || state == S_DRAIN
                  || state == S_REPORT;
    assign hit     = in_win & det_hit;
    assign cnt_nxt = (hit && cnt != '1) ? cnt + CNT_W'(1) : cnt;

`ifdef SD_SCHED_FIRST_HIT_EN
    logic [CNT_W-1:0] kcnt, first, first_nxt, res_first;

    // first == all-ones doubles as "no hit yet": k never reaches all-ones.
    assign first_nxt = (hit && first == '1) ? kcnt : first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kcnt      <= '0;
            first     <= '1;
            res_first <= '1;
        end else begin
            if (state == S_CLR) begin
                kcnt  <= '0;
                first <= '1;
            end else if (in_win) begin
                kcnt  <= kcnt + CNT_W'(1);
                first <= first_nxt;
            end
            if (state == S_REPORT)
                res_first <= first_nxt;
        end
    end

    assign bus.res_first = res_first;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (|bus.req) state_nxt = S_ARB;
            S_ARB:    state_nxt = found ? S_CLR : S_IDLE;
            S_CLR:    state_nxt = S_SHIFT;
            S_SHIFT:  if (idx == IW'(FRAME_W-1)) state_nxt = S_DRAIN;
            S_DRAIN:  if (idx == IW'(1)) state_nxt = S_REPORT;
            S_REPORT: state_nxt = (|bus.req) ? S_ARB : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            last        <= ID_W'(NREQ-1);
            gnt         <= '0;
            shreg       <= '0;
            idx         <= '0;
            cnt         <= '0;
            pattern_out <= 1'b0;
            det_rst     <= 1'b0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_id      <= '0;
            res_hits    <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != S_IDLE);
            gnt       <= '0;
            det_rst   <= 1'b0;
            res_valid <= 1'b0;
            unique case (state)
                S_ARB: begin
                    if (found) begin
                        gnt    <= NREQ'(1) << win;
                        shreg  <= bus.frame_data[win*FRAME_W +: FRAME_W];
                        res_id <= win;
                        last   <= win;
                    end
                end
                S_CLR: begin
                    det_rst <= 1'b1;
                    cnt     <= '0;
                    idx     <= '0;
                end
                S_SHIFT: begin
                    pattern_out <= shreg[FRAME_W-1];
                    shreg       <= shreg << 1;
                    cnt         <= cnt_nxt;
                    if (idx == IW'(FRAME_W-1))
                        idx <= '0;
                    else
                        idx <= idx + IW'(1);
                end
                S_DRAIN: begin
                    pattern_out <= 1'b0;
                    cnt         <= cnt_nxt;
                    idx         <= idx + IW'(1);
                end
                S_REPORT: begin
                    res_valid <= 1'b1;
                    res_hits  <= cnt_nxt;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt       = gnt;
    assign bus.res_valid = res_valid;
    assign bus.res_id    = res_id;
    assign bus.res_hits  = res_hits;
endmodule

// File: tb/tb_sd_sched.sv
// Bench for sd_sched with a behavioural detector (hit = 0-bit after any 1-bit).
// Build with SD_SCHED_FIRST_HIT_EN to also check res_first.
module tb_sd_sched;
    localparam int NREQ    = 2;
    localparam int FRAME_W = 15;
    localparam int CNT_W   = 4;
    localparam int ID_W    = 1;

    logic clk = 1'b0;
    logic rst;
    logic pattern_out, det_rst, det_hit, busy;
    logic seen, d1, dq, inj;
    int   cyc = 0;
    int   nres = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    sd_sched_if #(
        .NREQ(NREQ), .FRAME_W(FRAME_W),
        .CNT_W(CNT_W), .ID_W(ID_W)
    ) bus ();

    sd_sched #(
        .NREQ(NREQ), .FRAME_W(FRAME_W),
        .CNT_W(CNT_W), .ID_W(ID_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .pattern_out(pattern_out),
        .det_rst(det_rst),
        .det_hit(det_hit),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.res_valid === 1'b1) nres <= nres + 1;

    // Two-stage detector: output for bit k appears two cycles after bit k.
    always @(posedge clk or posedge det_rst or posedge rst) begin
        if (det_rst || rst) begin
            seen <= 1'b0;
            d1   <= 1'b0;
            dq   <= 1'b0;
        end else begin
            seen <= seen | pattern_out;
            d1   <= seen & ~pattern_out;
            dq   <= d1;
        end
    end
    assign det_hit = dq | inj;

    typedef struct {
        logic [1:0]  req;
        logic [14:0] f0;
        logic [14:0] f1;
        logic [1:0]  gnt;
        int          id;
        int          hits;
        int          first;
        bit          inj;
    } vec_t;

    vec_t tv[7];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_gnt(string nm, output int t);
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no gnt within 60 cycles", nm);
        end
    endtask

    task automatic wait_res(string nm, output int t);
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no res_valid within 60 cycles", nm);
        end
    endtask

    initial begin
        int tg, tr, prev, n0;
        logic [1:0] hg[3];
        int hh[3];

        tv[0] = '{2'b01, 15'h7000, 15'h0000, 2'b01, 0, 12, 3, 1'b0};
        tv[1] = '{2'b10, 15'h0000, 15'h7600, 2'b10, 1, 10, 3, 1'b0};
        tv[2] = '{2'b01, 15'h0000, 15'h0000, 2'b01, 0, 0, 15, 1'b1};
        tv[3] = '{2'b11, 15'h7600, 15'h7000, 2'b10, 1, 12, 3, 1'b0};
        tv[4] = '{2'b11, 15'h7000, 15'h7600, 2'b01, 0, 12, 3, 1'b0};
        tv[5] = '{2'b10, 15'h0000, 15'h4001, 2'b10, 1, 13, 1, 1'b0};
        tv[6] = '{2'b01, 15'h7fff, 15'h0000, 2'b01, 0, 0, 15, 1'b0};

        rst = 1'b1;
        inj = 1'b0;
        bus.req = '0;
        bus.frame_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pattern", 32'(pattern_out), 0);
        chk("rst_det_rst", 32'(det_rst), 0);
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_res_id", 32'(bus.res_id), 0);
        chk("rst_res_hits", 32'(bus.res_hits), 0);
`ifdef SD_SCHED_FIRST_HIT_EN
        chk("rst_res_first", 32'(bus.res_first), 15);
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            bus.frame_data = {tv[v].f1, tv[v].f0};
            bus.req = tv[v].req;
            wait_gnt($sformatf("v%0d_gnt", v), tg);
            if (tg >= 0) begin
                chk($sformatf("v%0d_gnt", v), 32'(bus.gnt), 32'(tv[v].gnt));
                bus.req = '0;
                inj = tv[v].inj;
                @(negedge clk);
                chk($sformatf("v%0d_gnt_pulse", v), 32'(bus.gnt), 0);
                chk($sformatf("v%0d_det_rst", v), 32'(det_rst), 1);
                chk($sformatf("v%0d_busy", v), 32'(busy), 1);
                repeat (3) @(negedge clk);
                inj = 1'b0;
                wait_res($sformatf("v%0d_res", v), tr);
                if (tr >= 0) begin
                    chk($sformatf("v%0d_latency", v), 32'(tr - tg), 19);
                    chk($sformatf("v%0d_id", v), 32'(bus.res_id), 32'(tv[v].id));
                    chk($sformatf("v%0d_hits", v), 32'(bus.res_hits), 32'(tv[v].hits));
`ifdef SD_SCHED_FIRST_HIT_EN
                    chk($sformatf("v%0d_first", v), 32'(bus.res_first), 32'(tv[v].first));
`endif
                    chk($sformatf("v%0d_idle", v), 32'(busy), 0);
                end
                inj = tv[v].inj;
                repeat (3) @(negedge clk);
                inj = 1'b0;
            end
            repeat (2) @(negedge clk);
        end

        // Reset in the middle of SHIFT.
        bus.frame_data = {15'h0000, 15'h7000};
        bus.req = 2'b01;
        wait_gnt("rst_mid_gnt", tg);
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("pattern_bit1", 32'(pattern_out), 1);
        n0 = nres;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_pattern", 32'(pattern_out), 0);
        chk("mid_rst_det_rst", 32'(det_rst), 0);
        chk("mid_rst_res_valid", 32'(bus.res_valid), 0);
        chk("mid_rst_gnt", 32'(bus.gnt), 0);
        chk("mid_rst_res_hits", 32'(bus.res_hits), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_res_after_rst", 32'(nres), 32'(n0));

        // Both requests held: strict alternation, 20-cycle grant spacing.
        hg[0] = 2'b01; hg[1] = 2'b10; hg[2] = 2'b01;
        hh[0] = 12;    hh[1] = 0;     hh[2] = 12;
        bus.frame_data = {15'h0000, 15'h7000};
        bus.req = 2'b11;
        prev = -1;
        tr = -1;
        for (int g = 0; g < 3; g++) begin
            wait_gnt($sformatf("held%0d_gnt", g), tg);
            if (tg < 0) break;
            chk($sformatf("held%0d_gnt", g), 32'(bus.gnt), 32'(hg[g]));
            if (prev >= 0)
                chk($sformatf("held%0d_spacing", g), 32'(tg - prev), 20);
            prev = tg;
            if (g == 2) bus.req = '0;
            wait_res($sformatf("held%0d_res", g), tr);
            if (tr < 0) break;
            chk($sformatf("held%0d_hits", g), 32'(bus.res_hits), 32'(hh[g]));
            chk($sformatf("held%0d_id", g), 32'(bus.res_id), 32'(g % 2));
        end

        // Request raised during the REPORT (res_valid) cycle.
        if (tr >= 0) begin
            bus.frame_data = {15'h0000, 15'h7600};
            bus.req = 2'b01;
            wait_gnt("late_gnt", tg);
            if (tg >= 0) begin
                chk("late_gnt_delay", 32'(tg - tr), 2);
                chk("late_gnt", 32'(bus.gnt), 1);
                bus.req = '0;
                wait_res("late_res", tr);
                if (tr >= 0) begin
                    chk("late_hits", 32'(bus.res_hits), 10);
                    chk("late_id", 32'(bus.res_id), 0);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
